// File: rtl/pulse_period_monitor.sv
// Purpose : receive-side checker for a periodic single-cycle pulse stream; measures the
//           pulse interval, locks once consecutive intervals equal PERIOD, and flags early
//           or missing pulses. Latency: all outputs registered, valid one edge after the
//           sampled pulse. Backpressure: none (pure observer, one sample per clk).
// Ports   : clk/reset (sync, active-high); pulse_in monitored stream;
//           locked = state is LOCKED; err = one-cycle fault strobe while locked;
//           interval/interval_vld = last measured interval and its update strobe;
//           err_count = saturating fault counter.
// Option  : PULSE_MON_STICKY_EN adds clr_sticky input and sticky_err output
//           (sticky copy of err, cleared by reset or clr_sticky; set wins over clear).
module pulse_period_monitor #(
    parameter int PERIOD     = 3,
    parameter int CW         = 4,
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pulse_in,
`ifdef PULSE_MON_STICKY_EN
    input  logic          clr_sticky,
    output logic          sticky_err,
`endif
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] interval,
    output logic          interval_vld,
    output logic [7:0]    err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);

    localparam logic [CW-1:0] P_CNT   = CW'(PERIOD);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] LOSS_V  = BW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [GW-1:0]   r_good;
    logic [GW-1:0]   w_good_nxt;
    logic [GW-1:0]   w_good_inc;
    logic [BW-1:0]   r_bad;
    logic [BW-1:0]   w_bad_nxt;
    logic [BW-1:0]   w_bad_inc;

    logic            r_locked;
    logic            r_err;
    logic            w_err_nxt;
    logic [CW-1:0]   r_interval;
    logic [CW-1:0]   w_interval_nxt;
    logic            r_vld;
    logic            w_vld_nxt;
    logic [7:0]      r_err_count;
    logic [7:0]      w_err_count_nxt;

    logic            w_meas_ok;
    logic            w_miss;
    logic            w_fault;

    // The counter value before the edge is the measured interval of a real pulse.
    assign w_meas_ok  = (r_cnt == P_CNT);
    assign w_good_inc = r_good + GW'(1);
    assign w_bad_inc  = r_bad + BW'(1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_good_nxt      = r_good;
        w_bad_nxt       = r_bad;
        w_err_nxt       = 1'b0;
        w_vld_nxt       = 1'b0;
        w_interval_nxt  = r_interval;
        w_err_count_nxt = r_err_count;
        w_miss          = 1'b0;
        w_fault         = 1'b0;

        case (r_state)
            S_HUNT: begin
                // First pulse only establishes a reference; nothing to measure yet.
                if (pulse_in) begin
                    w_state_nxt = S_ACQ;
                    w_good_nxt  = '0;
                end
            end

            S_ACQ: begin
                if (pulse_in) begin
                    w_vld_nxt      = 1'b1;
                    w_interval_nxt = r_cnt;
                    if (w_meas_ok) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LOCK_V) begin
                            w_state_nxt = S_LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else begin
                        // Wrong interval: restart the run, this pulse is the new reference.
                        w_good_nxt = '0;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    // Counter saturated: the stream is gone, reference is meaningless.
                    w_state_nxt = S_HUNT;
                end
            end

            S_LOCKED: begin
                if (pulse_in) begin
                    w_vld_nxt      = 1'b1;
                    w_interval_nxt = r_cnt;
                    if (w_meas_ok) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_fault = 1'b1;
                    end
                end else if (r_cnt == P_CNT) begin
                    // Expected pulse absent: fault now and act as if it arrived, so a
                    // dead input keeps faulting once per PERIOD.
                    w_miss  = 1'b1;
                    w_fault = 1'b1;
                end

                if (w_fault) begin
                    w_err_nxt = 1'b1;
                    if (r_err_count != 8'hFF) begin
                        w_err_count_nxt = r_err_count + 8'd1;
                    end
                    w_bad_nxt = w_bad_inc;
                    if (w_bad_inc == LOSS_V) begin
                        w_state_nxt = S_ACQ;
                        w_good_nxt  = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase

        // Real or virtual pulse restarts the interval at 1; otherwise count up and
        // hold at all-ones.
        if (pulse_in || w_miss) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_interval  <= '0;
            r_vld       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
            r_err       <= w_err_nxt;
            r_interval  <= w_interval_nxt;
            r_vld       <= w_vld_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked       = r_locked;
    assign err          = r_err;
    assign interval     = r_interval;
    assign interval_vld = r_vld;
    assign err_count    = r_err_count;

`ifdef PULSE_MON_STICKY_EN
    logic r_sticky;

    // Set term is OR-ed last so a coincident clear cannot hide a new fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= w_err_nxt | (r_sticky & ~clr_sticky);
        end
    end

    assign sticky_err = r_sticky;
`endif

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
- Receive-side checker for periodic single-cycle pulse streams, such as the divide-by-N strobes produced by the counter FSMs in this design.
- Measures the interval between pulses and locks when consecutive intervals equal PERIOD.
- Flags early and missing pulses, counts errors, and drops lock after repeated faults.
- Sits on the same clock domain as the pulse source.

Parameters:
- PERIOD, 3, expected pulse interval in clock cycles; legal range 2..2^CW-2.
- CW, 4, width of the interval counter and the interval output.
- LOCK_COUNT, 2, consecutive correct intervals needed to enter LOCKED (>=1).
- LOSS_COUNT, 2, consecutive faults in LOCKED that drop back to ACQ (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pulse_in  input  1  monitored pulse stream, sampled every clk edge
- locked  output  1  high while state is LOCKED
- err  output  1  one-cycle strobe for an early, late or missing pulse while LOCKED
- interval  output  CW  last measured interval
- interval_vld  output  1  one-cycle strobe when interval updates
- err_count  output  8  fault counter, saturates at 255

Behaviour:
- Reset: this is already decided. There is one clock; reset is synchronous and active-high. On an edge with reset=1: state=HUNT, cnt=0, good=0, bad=0, and all outputs 0 (interval=0, err_count=0).
- Register timing: every output is registered and updates on the same edge as the state.
- cnt: on an edge sampling pulse_in=1, or a virtual pulse (see miss), cnt<=1; otherwise cnt<=cnt+1, saturating at 2^CW-1.
- Measured value: on a real pulse, meas = cnt (value before the edge). interval<=meas and interval_vld<=1, except in HUNT, where no reference exists.
- HUNT:
  - pulse -> ACQ, good<=0.
- ACQ:
  - pulse with meas==PERIOD: good<=good+1; if good+1==LOCK_COUNT -> LOCKED, bad<=0.
  - pulse with meas!=PERIOD: good<=0, stay in ACQ; this pulse becomes the new reference.
  - cnt at 2^CW-1 with no pulse -> HUNT.
  - No err is generated in ACQ or HUNT.
- LOCKED:
  - pulse with meas==PERIOD: bad<=0.
  - pulse with meas<PERIOD (early): fault.
  - cnt==PERIOD and pulse_in==0 (miss): fault, and treat as a virtual pulse (cnt<=1). Repeated misses therefore fault every PERIOD cycles.
  - Fault actions: err<=1 for one cycle; err_count<=err_count+1 (saturating at 255); bad<=bad+1.
  - If bad+1==LOSS_COUNT: go to ACQ with good<=0; the faulting pulse (real or virtual) is the reference.
  - A late pulse cannot occur in LOCKED because the miss fires first.
- locked: registered, equals (next state==LOCKED). It rises on the edge that samples the LOCK_COUNT-th good pulse.
- Simultaneous events: reset has priority over everything. A real pulse at cnt==PERIOD is good, not a miss.
- Reset mid-lock: next cycle is HUNT with locked=0; err_count is cleared.

Optional Feature:
- Macro: PULSE_MON_STICKY_EN.
- When defined:
  - Adds input clr_sticky (1 bit) and output sticky_err (1 bit).
  - sticky_err is set on any edge where err is being set; it stays set until reset or clr_sticky=1.
  - If set and clear coincide, set wins.
- When undefined: both ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Lock acquisition (defaults):
  - Stimulus: reset 2 cycles, then pulses at cycles 0,3,6,9.
  - Response: no interval_vld at cycle 0; interval=3 and interval_vld after the cycle-3 and cycle-6 edges; locked=1 after the cycle-6 edge; err never asserted.
- Single miss:
  - Stimulus: locked, pulses every 3 cycles, pulse at cycle 15 dropped, pulse at 18 present.
  - Response: err=1 for one cycle after the cycle-15 edge; err_count=1; locked stays 1; cycle-18 pulse gives interval=3 and bad clears.
- Early pulse then loss:
  - Stimulus: locked, pulses at 21 and 23 (interval 2), then 25 (interval 2).
  - Response: err after the 23 edge and after the 25 edge; err_count +2; locked=0 after the 25 edge; state ACQ.
  - Follow-up: pulses at 28 and 31 relock after the 31 edge.
- Stuck-low input:
  - Stimulus: locked, pulse_in held 0.
  - Response: err every 3 cycles; after the 2nd miss locked=0 (ACQ); once cnt reaches 15, state is HUNT; err stops in ACQ and HUNT.
- Saturation and reset:
  - Stimulus: force 300 early faults by alternating intervals with LOSS_COUNT=255, then assert reset mid-lock.
  - Response: err_count holds at 255; one cycle after reset, locked=0, err_count=0, interval=0.
- Sticky (PULSE_MON_STICKY_EN defined):
  - Stimulus: one miss, then clr_sticky on the same cycle as a second err.
  - Response: sticky_err=1 after the first err and remains 1 after the coincident clear; a later clr_sticky alone clears it.
